lamp_sequencer: RTL and testbench
=================================

# lamp_sequencer

Bound-flasher lamp sequencer: the state machine and up/down lamp counter that produces the `counter` value consumed by `kickback_match_generator` and acts on the `kickback_match` it returns. It converts a `flick` request into the fixed on/off sweep pattern over 16 lamps, restarting a sweep segment on kickback. The module sits between the top-level `flick` input and the lamp output pins.

## Interface
- `LAMP_NUM`, 16: number of lamps. `counter` range is 0..`LAMP_NUM`.
- `KICK_LO`, 5: low kickback point and floor of segment UP2.
- `KICK_HI`, 10: high kickback point and top of segment UP2.
- `TICK_DIV`, 4: clock cycles per step. Used only when `LAMP_SEQ_PRESCALE_EN` is defined.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flick` in 1: start request; sampled only in IDLE.
- `kickback_match` in 1: from `kickback_match_generator`. It is combinational on `flick` and `counter`, and asserts when `flick` is high and `counter` equals 5 or 10.
- `counter` out 5: registered count of lit lamps, 0..16.
- `lamp` out 16: registered thermometer code; `lamp[i]` = (i < `counter`).
- `busy` out 1: registered; high in every state except IDLE.

## Operation
- A "step" is a clock edge with step enable high. Without the macro, every edge is a step.
- State, `counter` and `lamp` update together on each step. Between steps they hold.
- The FSM evaluates the conditions below in order; the first true condition wins.
- IDLE (`counter` 0): if `flick`=1, go to UP1 with `counter`=1. Otherwise hold.
- UP1: if `kickback_match`, go to KB1 with `counter`−1. Else if `counter`=16, go to DOWN1 with `counter`=15. Else `counter`+1.
- DOWN1: if `counter`=5, go to UP2 with `counter`=6. Else `counter`−1.
- UP2: if `kickback_match` (reachable only at 10), go to KB2 with `counter`=9. Else if `counter`=10, go to DOWN2 with `counter`=9. Else `counter`+1.
- KB1: if `counter`=0, go to UP1 with `counter`=1. Else `counter`−1.
- KB2: if `counter`=5, go to UP2 with `counter`=6. Else `counter`−1.
- DOWN2: if `counter`=0, go to UP3 with `counter`=1. Else `counter`−1.
- UP3: if `counter`=5, go to DOWN3 with `counter`=4. Else `counter`+1. `kickback_match` is ignored.
- DOWN3: if `counter`=0, go to IDLE with `counter` held at 0. Else `counter`−1.
- Holding `flick`=1 in UP1 loops UP1↔KB1 indefinitely. This is required behaviour.
- `kickback_match` is ignored in every state except UP1 and UP2.
- `counter` never leaves 0..16. Unreachable encodings recover to IDLE with `counter`=0.

## Timing
- Reset (asynchronous, any state, mid-sweep included): state IDLE, `counter`=0, `lamp`=16'h0000, `busy`=0, prescaler cleared.
- Latency from `flick` sampled high in IDLE to `lamp`=16'h0001 is one step.
- `lamp` and `counter` always change on the same edge. `lamp` is never a cycle behind.
- A full sweep with no kickback:
  - `counter` reaches 16 at step 16.
  - `counter` returns to 0 at step 52.
  - State is IDLE with `busy`=0 after step 53.
- `busy` rises on the step leaving IDLE. It falls on the step entering IDLE.

## Configuration
- `LAMP_SEQ_PRESCALE_EN` defined:
  - Step enable is a registered pulse from a mod-`TICK_DIV` counter, producing one step per `TICK_DIV` clocks.
  - The prescaler free-runs from reset.
  - `flick` is sampled only on step edges.
- Not defined: step enable is tied high, `TICK_DIV` is unused, and no prescaler registers exist.

## Structure
- `bound_flasher_pkg` holds:
  - state enum {IDLE, UP1, DOWN1, UP2, KB1, KB2, DOWN2, UP3, DOWN3};
  - `LAMP_NUM`, `KICK_LO` and `KICK_HI` defaults;
  - the counter width constant (5).
- One sub-module, `step_prescaler`, instantiated only under the macro.
- The thermometer decode of `lamp` is local logic.

## Test plan
- Reset with `flick`=0 → `counter`=0, `lamp`=0, `busy`=0. Hold 20 cycles → no change.
- Pulse `flick` for 1 cycle, with the bench model of `kickback_match_generator` attached → full sweep. `counter`=16 at step 16, 5 at step 27, 10 at step 32, 0 at step 42, 5 at step 47, 0 at step 52. IDLE at step 53.
- Raise `flick` again when UP1 reaches `counter`=5 → KB1. `counter` runs 4..0, then UP1 resumes at 1. Drop `flick` → sweep completes normally.
- Hold `flick`=1 only during UP2 at `counter`=10 → KB2. `counter` runs 9..5, then 6 in UP2, then DOWN2 on the next visit to 10.
- Assert `rst_n`=0 asynchronously mid-DOWN1 at `counter`=12 → outputs 0 immediately, without waiting for an edge. After release, state is IDLE.
- With `LAMP_SEQ_PRESCALE_EN` defined and `TICK_DIV`=4 → `counter` advances exactly every 4 clocks. A `flick` pulse between steps is ignored.

Source files
------------

// File: rtl/bound_flasher_pkg.sv
// Shared types and defaults for the bound-flasher lamp sequencer.
package bound_flasher_pkg;

  localparam int CNT_W        = 5;
  localparam int LAMP_NUM_DEF = 16;
  localparam int KICK_LO_DEF  = 5;
  localparam int KICK_HI_DEF  = 10;

  typedef enum logic [3:0] {
    IDLE,
    UP1,
    DOWN1,
    UP2,
    KB1,
    KB2,
    DOWN2,
    UP3,
    DOWN3
  } state_t;

endpackage

// File: rtl/step_prescaler.sv
// Free-running mod-TICK_DIV divider producing a registered one-clock step pulse.
// Only instantiated when LAMP_SEQ_PRESCALE_EN is defined.
module step_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic step_en
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic          wrap;

  always_comb begin
    wrap   = (div_q == DW'(TICK_DIV - 1));
    div_d  = wrap ? '0 : div_q + DW'(1);
    tick_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign step_en = tick_q;

endmodule

// File: rtl/lamp_sequencer.sv
// Bound-flasher FSM and up/down lamp counter with registered thermometer lamp output.
// Optional step prescaler enabled by defining LAMP_SEQ_PRESCALE_EN.
module lamp_sequencer
  import bound_flasher_pkg::*;
#(
  parameter int LAMP_NUM = LAMP_NUM_DEF,
  parameter int KICK_LO  = KICK_LO_DEF,
  parameter int KICK_HI  = KICK_HI_DEF
`ifdef LAMP_SEQ_PRESCALE_EN
  ,
  parameter int TICK_DIV = 4
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flick,
  input  logic                kickback_match,
  output logic [CNT_W-1:0]    counter,
  output logic [LAMP_NUM-1:0] lamp,
  output logic                busy,
  output state_t              state_dbg
);

  localparam logic [CNT_W-1:0] TOP_C = CNT_W'(LAMP_NUM);
  localparam logic [CNT_W-1:0] LO_C  = CNT_W'(KICK_LO);
  localparam logic [CNT_W-1:0] HI_C  = CNT_W'(KICK_HI);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic step_en;

`ifdef LAMP_SEQ_PRESCALE_EN
  step_prescaler #(.TICK_DIV(TICK_DIV)) u_step_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_en (step_en)
  );
`else
  assign step_en = 1'b1;
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      counter_q, counter_d;
  logic [LAMP_NUM-1:0]   lamp_q, lamp_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    if (step_en) begin
      unique case (state_q)
        IDLE: begin
          if (flick) begin
            state_d   = UP1;
            counter_d = ONE_C;
          end
        end
        UP1: begin
          if (kickback_match) begin
            state_d   = KB1;
            counter_d = counter_q - ONE_C;
          end else if (counter_q == TOP_C) begin
            state_d   = DOWN1;
            counter_d = TOP_C - ONE_C;
          end else begin
            counter_d = counter_q + ONE_C;
          end
        end
        DOWN1: begin
          if (counter_q == LO_C) begin
            state_d   = UP2;
            counter_d = LO_C + ONE_C;
          end else begin
            counter_d = counter_q - ONE_C;
          end
        end
        UP2: begin
          if (kickback_match) begin
            state_d   = KB2;
            counter_d = HI_C - ONE_C;
          end else if (counter_q == HI_C) begin
            state_d   = DOWN2;
            counter_d = HI_C - ONE_C;
          end else begin
            counter_d = counter_q + ONE_C;
          end
        end
        KB1: begin
          if (counter_q == '0) begin
            state_d   = UP1;
            counter_d = ONE_C;
          end else begin
            counter_d = counter_q - ONE_C;
          end
        end
        KB2: begin
          if (counter_q == LO_C) begin
            state_d   = UP2;
            counter_d = LO_C + ONE_C;
          end else begin
            counter_d = counter_q - ONE_C;
          end
        end
        DOWN2: begin
          if (counter_q == '0) begin
            state_d   = UP3;
            counter_d = ONE_C;
          end else begin
            counter_d = counter_q - ONE_C;
          end
        end
        UP3: begin
          if (counter_q == LO_C) begin
            state_d   = DOWN3;
            counter_d = LO_C - ONE_C;
          end else begin
            counter_d = counter_q + ONE_C;
          end
        end
        DOWN3: begin
          if (counter_q == '0) begin
            state_d   = IDLE;
            counter_d = '0;
          end else begin
            counter_d = counter_q - ONE_C;
          end
        end
        default: begin
          state_d   = IDLE;
          counter_d = '0;
        end
      endcase
    end

    // Decoded from the next count so lamp lands on the same edge as counter.
    lamp_d = '0;
    for (int i = 0; i < LAMP_NUM; i++) begin
      lamp_d[i] = (CNT_W'(i) < counter_d);
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      lamp_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      lamp_q    <= lamp_d;
      busy_q    <= busy_d;
    end
  end

  assign counter   = counter_q;
  assign lamp      = lamp_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Scoreboard bench for lamp_sequencer: driver pushes {state,busy,counter} per step,
// a monitor pops one entry #1 after each clock edge and checks counter, lamp, busy, state.
module tb_lamp_sequencer;
  import bound_flasher_pkg::*;

  localparam int W = 10;

  logic        clk;
  logic        rst_n;
  logic        flick;
  logic        kickback_match;
  logic [4:0]  counter;
  logic [15:0] lamp;
  logic        busy;
  state_t      state_dbg;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  lamp_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flick          (flick),
    .kickback_match (kickback_match),
    .counter        (counter),
    .lamp           (lamp),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  // Model of kickback_match_generator.
  assign kickback_match = flick && ((counter == 5'd5) || (counter == 5'd10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] thermo(input int c);
    logic [16:0] t;
    t = (17'd1 << c) - 17'd1;
    return t[15:0];
  endfunction

  task automatic check_idle_now(input string tag);
    check({tag, "_counter"}, int'(counter), 0);
    check({tag, "_lamp"},    int'(lamp),    0);
    check({tag, "_busy"},    int'(busy),    0);
    check({tag, "_state"},   int'(state_dbg), int'(IDLE));
  endtask

  // Monitor: one scoreboard entry per clock edge while entries are pending.
  initial begin
    logic [W-1:0] e;
    int c;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = int'(e[4:0]);
        check("counter", int'(counter), c);
        check("lamp", int'(lamp), int'(thermo(c)));
        check("busy", int'(busy), int'(e[5]));
        check("state", int'(state_dbg), int'(e[9:6]));
      end
    end
  end

  // Set flick for the next edge and record what that edge must produce.
  task automatic drive(input logic f, input state_t s, input int c);
    @(posedge clk);
    #3;
    flick = f;
    exp_q.push_back({s, (s != IDLE), 5'(c)});
  endtask

  task automatic ramp(input logic f, input state_t s, input int from, input int to);
    int c;
    c = from;
    forever begin
      drive(f, s, c);
      if (c == to) break;
      c = (from <= to) ? c + 1 : c - 1;
    end
  endtask

  task automatic tail_from_up2();
    ramp(0, UP2, 6, 10);
    ramp(0, DOWN2, 9, 0);
    ramp(0, UP3, 1, 5);
    ramp(0, DOWN3, 4, 0);
    drive(0, IDLE, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 8) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    flick = 1'b0;
    #12;
    check_idle_now("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

`ifdef LAMP_SEQ_PRESCALE_EN
    begin
      int n;
      flick = 1'b1;
      n = 0;
      while (counter == 5'd0 && n < 16) begin
        @(posedge clk);
        #1;
        n++;
      end
      flick = 1'b0;
      check("pre_first_step", int'(counter), 1);
      for (int k = 2; k <= 9; k++) begin
        repeat (3) @(posedge clk);
        #1;
        check("pre_hold", int'(counter), k - 1);
        @(posedge clk);
        #1;
        check("pre_step", int'(counter), k);
      end
    end
`else
    // Idle hold with flick low.
    for (int i = 0; i < 20; i++) drive(0, IDLE, 0);

    // Full sweep, single-cycle flick.
    drive(1, UP1, 1);
    ramp(0, UP1, 2, 16);
    ramp(0, DOWN1, 15, 5);
    tail_from_up2();

    // Flick raised while UP1 is at 5: kickback to KB1, then normal sweep.
    drive(1, UP1, 1);
    ramp(0, UP1, 2, 5);
    drive(1, KB1, 4);
    ramp(0, KB1, 3, 0);
    drive(0, UP1, 1);
    ramp(0, UP1, 2, 16);
    ramp(0, DOWN1, 15, 5);
    tail_from_up2();

    // Flick high only at UP2 top: kickback to KB2.
    drive(1, UP1, 1);
    ramp(0, UP1, 2, 16);
    ramp(0, DOWN1, 15, 5);
    ramp(0, UP2, 6, 10);
    drive(1, KB2, 9);
    ramp(0, KB2, 8, 5);
    tail_from_up2();

    // Kickback ignored in DOWN1 and UP3.
    drive(1, UP1, 1);
    ramp(0, UP1, 2, 16);
    ramp(0, DOWN1, 15, 11);
    drive(1, DOWN1, 10);
    drive(1, DOWN1, 9);
    ramp(0, DOWN1, 8, 5);
    ramp(0, UP2, 6, 10);
    ramp(0, DOWN2, 9, 0);
    ramp(0, UP3, 1, 5);
    drive(1, DOWN3, 4);
    ramp(0, DOWN3, 3, 0);
    drive(0, IDLE, 0);

    // Asynchronous reset mid-DOWN1 at 12.
    drive(1, UP1, 1);
    ramp(0, UP1, 2, 16);
    ramp(0, DOWN1, 15, 12);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check_idle_now("async_reset");
    @(posedge clk);
    #1;
    check_idle_now("in_reset");
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) drive(0, IDLE, 0);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
